// File: rtl/hmmm_loader_pkg.sv
// Shared definitions for the hmmm program loader: byte/word geometry and FSM state encodings.
package hmmm_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 2;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HI   = 3'd1;
    localparam logic [2:0] ST_LO   = 3'd2;
    localparam logic [2:0] ST_ADDR = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;
    localparam logic [2:0] ST_CSUM = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;
    localparam logic [2:0] ST_ERR  = 3'd7;

endpackage

// File: rtl/hmmm_loader_word_assembler.sv
// Packs big-endian byte pairs into one program word; with HMMM_LOADER_CHECKSUM_EN it also
// keeps a running XOR of every data byte of the current frame.
module hmmm_loader_word_assembler
    import hmmm_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              clear,
    input  logic              load_hi,
    input  logic              load_lo,
    output logic [WORD_W-1:0] word
`ifdef HMMM_LOADER_CHECKSUM_EN
    ,
    output logic [BYTE_W-1:0] csum
`endif
);

    logic [BYTE_W-1:0] hi_q;

    // The word only updates once its low byte arrives, so it is stable through ADDR/DATA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            word <= '0;
        end else if (clear) begin
            hi_q <= '0;
            word <= '0;
        end else begin
            if (load_hi) hi_q <= byte_in;
            if (load_lo) word <= {hi_q, byte_in};
        end
    end

`ifdef HMMM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (clear) begin
            csum <= '0;
        end else if (load_hi || load_lo) begin
            csum <= csum ^ byte_in;
        end
    end
`endif

endmodule

// File: rtl/hmmm_loader.sv
// Byte-stream program loader for the hmmm core: writes a COUNT-prefixed word image into core RAM
// and holds the core in reset until done. Optional trailing XOR checksum: HMMM_LOADER_CHECKSUM_EN.
module hmmm_loader
    import hmmm_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pgrm_addr,
    output logic              pgrm_data,
    output logic [DATA_W-1:0] bus_o,
    output logic              bus_oe,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int REM_W = ADDR_W + 1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [REM_W-1:0]  remaining;
    logic [REM_W-1:0]  frame_len;
    logic [WORD_W-1:0] word;
    logic              xfer;
    logic              accept_count;
    logic              load_hi;
    logic              load_lo;

    assign xfer         = in_valid & in_ready;
    assign accept_count = xfer && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign load_hi      = xfer && (state == ST_HI);
    assign load_lo      = xfer && (state == ST_LO);

    // COUNT of zero selects a full RAM image (2**ADDR_W words).
    assign frame_len = (in_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : REM_W'(in_data);

`ifdef HMMM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       error_q;

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    hmmm_loader_word_assembler u_assembler (
        .clk     (clk),
        .rst     (rst),
        .byte_in (in_data),
        .clear   (accept_count),
        .load_hi (load_hi),
        .load_lo (load_lo),
        .word    (word)
`ifdef HMMM_LOADER_CHECKSUM_EN
        ,
        .csum    (csum)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            pgrm_addr <= 1'b0;
            pgrm_data <= 1'b0;
            bus_o     <= '0;
            bus_oe    <= 1'b0;
            cpu_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            remaining <= '0;
`ifdef HMMM_LOADER_CHECKSUM_EN
            error_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (xfer) begin
                        remaining <= frame_len;
                        addr      <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cpu_rst   <= 1'b0;
`ifdef HMMM_LOADER_CHECKSUM_EN
                        error_q   <= 1'b0;
`endif
                        state     <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (xfer) state <= ST_LO;
                end
                ST_LO: begin
                    // Stall the stream for the two bus cycles that follow each word.
                    if (xfer) begin
                        in_ready  <= 1'b0;
                        bus_oe    <= 1'b1;
                        bus_o     <= DATA_W'(addr);
                        pgrm_addr <= 1'b1;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    pgrm_addr <= 1'b0;
                    pgrm_data <= 1'b1;
                    bus_o     <= word;
                    state     <= ST_DATA;
                end
                ST_DATA: begin
                    pgrm_data <= 1'b0;
                    bus_oe    <= 1'b0;
                    bus_o     <= '0;
                    in_ready  <= 1'b1;
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == REM_W'(1)) begin
`ifdef HMMM_LOADER_CHECKSUM_EN
                        state   <= ST_CSUM;
`else
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b1;
                        busy    <= 1'b0;
`endif
                    end else begin
                        state <= ST_HI;
                    end
                end
`ifdef HMMM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (in_data == csum) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b1;
                        end else begin
                            state   <= ST_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hmmm_loader.sv
// Self-checking bench for hmmm_loader: a small core model captures RAM writes, and expected
// writes/RAM contents come from the frame words the bench itself generates.
module tb_hmmm_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        pgrm_addr;
    logic        pgrm_data;
    logic [15:0] bus_o;
    logic        bus_oe;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    wire  [15:0] bus;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    int          compared;
    int          mismatched;
    wr_t         write_q[$];
    logic [15:0] core_ram[256];
    logic [7:0]  mar;
    logic [7:0]  last_wr_addr;
    logic [15:0] fw[256];

    assign bus = bus_oe ? bus_o : 16'hzzzz;

    hmmm_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pgrm_addr (pgrm_addr),
        .pgrm_data (pgrm_data),
        .bus_o     (bus_o),
        .bus_oe    (bus_oe),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Core-side model: MAR latch plus RAM, checked against the expected write order.
    always @(negedge clk) begin
        if (rst) begin
            check_output("pgrm_exclusive", pgrm_addr & pgrm_data, 0);
            check_output("bus_oe_window", bus_oe, pgrm_addr | pgrm_data);
            if (pgrm_addr) begin
                if (write_q.size() == 0) check_output("unexpected_addr_phase", pgrm_addr, 0);
                else check_output("addr_bus", bus, {8'h00, write_q[0].addr});
                mar = bus[7:0];
            end
            if (pgrm_data) begin
                if (write_q.size() == 0) begin
                    check_output("unexpected_write", pgrm_data, 0);
                end else begin
                    check_output("write_mar", mar, write_q[0].addr);
                    check_output("write_data", bus, write_q[0].data);
                    void'(write_q.pop_front());
                end
                core_ram[mar] = bus;
                last_wr_addr  = mar;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_in_ready"}, in_ready, 1);
        check_output({tag, "_pgrm_addr"}, pgrm_addr, 0);
        check_output({tag, "_pgrm_data"}, pgrm_data, 0);
        check_output({tag, "_bus_oe"}, bus_oe, 0);
        check_output({tag, "_bus_o"}, bus_o, 0);
        check_output({tag, "_cpu_rst"}, cpu_rst, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_error"}, error, 0);
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken, valid left high.
    task automatic send_byte(input logic [7:0] b, output int stall);
        stall    = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && stall < 50) begin
            @(negedge clk);
            stall++;
        end
        if (!in_ready) check_output("accept_timeout", in_ready, 1);
        else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic apply_stimulus(input int n, input bit gaps, input bit bad_csum);
        logic [7:0] x;
        int         stall;
        x = 8'h00;
        send_byte(n[7:0], stall);
        check_output("load_busy", busy, 1);
        check_output("load_cpu_rst", cpu_rst, 0);
        check_output("load_done", done, 0);
        for (int i = 0; i < n; i++) begin
            x = x ^ fw[i][15:8] ^ fw[i][7:0];
            write_q.push_back('{addr: 8'(i % 256), data: fw[i]});
            if (gaps) idle($urandom_range(0, 3));
            send_byte(fw[i][15:8], stall);
            if (!gaps && i > 0) check_output("stall_cycles", stall, 2);
            if (gaps) idle($urandom_range(0, 2));
            send_byte(fw[i][7:0], stall);
        end
`ifdef HMMM_LOADER_CHECKSUM_EN
        send_byte(x ^ {7'd0, bad_csum}, stall);
`else
        if (bad_csum) check_output("csum_unsupported", error, 0);
`endif
        in_valid = 1'b0;
    endtask

    task automatic wait_status(input logic exp_done, input logic exp_error);
        int cycles;
        cycles = 0;
        while (!(done || error) && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check_output("status_reached", done | error, 1);
        check_output("status_done", done, exp_done);
        check_output("status_error", error, exp_error);
        check_output("status_cpu_rst", cpu_rst, exp_done);
        check_output("status_busy", busy, 0);
        check_output("status_in_ready", in_ready, 1);
        check_output("pending_writes", write_q.size(), 0);
    endtask

    task automatic random_frame(input int n, input bit gaps);
        for (int i = 0; i < n; i++) fw[i] = 16'($urandom);
        apply_stimulus(n, gaps, 1'b0);
        wait_status(1'b1, 1'b0);
        for (int i = 0; i < n; i++) check_output("ram_random", core_ram[i], fw[i]);
    endtask

    initial begin
        int stall;
        int cycles;
        compared   = 0;
        mismatched = 0;
        mar        = 8'h00;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        rst        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] directed two-word frame with stream gaps");
        fw[0] = 16'h1234;
        fw[1] = 16'hABCD;
        apply_stimulus(2, 1'b1, 1'b0);
        wait_status(1'b1, 1'b0);
        check_output("ram0_1234", core_ram[0], 16'h1234);
        check_output("ram1_abcd", core_ram[1], 16'hABCD);

        $display("[TB] random frames, continuous and gapped valid");
        random_frame($urandom_range(3, 20), 1'b0);
        random_frame($urandom_range(3, 20), 1'b1);

        $display("[TB] full-RAM frame (COUNT=0)");
        random_frame(256, 1'b0);
        check_output("full_last_addr", last_wr_addr, 8'hFF);
        check_output("full_ram0_kept", core_ram[0], fw[0]);

        $display("[TB] reload from DONE");
        fw[0] = 16'h0001;
        apply_stimulus(1, 1'b0, 1'b0);
        wait_status(1'b1, 1'b0);
        check_output("reload_ram0", core_ram[0], 16'h0001);

        $display("[TB] async reset during DATA");
        fw[0] = 16'($urandom);
        send_byte(8'd3, stall);
        write_q.push_back('{addr: 8'h00, data: fw[0]});
        send_byte(fw[0][15:8], stall);
        send_byte(fw[0][7:0], stall);
        in_valid = 1'b0;
        cycles = 0;
        while (!pgrm_data && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check_output("reached_data", pgrm_data, 1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midload_reset");
        @(negedge clk);
        check_output("midload_cpu_rst_held", cpu_rst, 0);
        rst = 1'b1;
        write_q.delete();
        @(negedge clk);
        random_frame($urandom_range(3, 10), 1'b0);

`ifdef HMMM_LOADER_CHECKSUM_EN
        $display("[TB] checksum good and bad");
        fw[0] = 16'h0F0F;
        apply_stimulus(1, 1'b0, 1'b0);
        wait_status(1'b1, 1'b0);
        fw[0] = 16'h0F0F;
        apply_stimulus(1, 1'b0, 1'b1);
        wait_status(1'b0, 1'b1);
        random_frame($urandom_range(2, 6), 1'b0);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
